// File: rtl/pipe_fifo.sv
// First-word fall-through FIFO between pipeline stages, with valid/ready on both sides,
// an occupancy count, and a synchronous flush for redirects.
module pipe_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_flush,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_WIDTH-1:0]   i_din,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DATA_WIDTH-1:0]   o_dout,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  push;
  logic                  pop;

  // Ready comes from registered state only, so a full FIFO refuses a write even while popping.
  assign o_ready = (count != FULL_COUNT) & ~rst;
  assign o_valid = (count != '0);
  assign o_dout  = mem[rd_ptr];
  assign o_count = count;

  assign push = i_valid & o_ready;
  assign pop  = o_valid & i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (i_flush) begin
      // Stale mem contents stay behind; they cannot be seen while o_valid is low.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= i_din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_fifo.sv
// Self-checking bench for pipe_fifo: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_pipe_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          i_flush;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_din;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_dout;
  logic [CW-1:0] o_count;

  int checks;
  int errors;

  pipe_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_din   (i_din),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_dout  (o_dout),
    .o_count (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          flush;
    logic          valid;
    logic          ready;
    logic [DW-1:0] din;
    logic          expValid;
    int            expCount;
    logic          chkDout;
    logic [DW-1:0] expDout;
    logic          expReady;
  } vec_t;

  vec_t vecs[$];

  // Drive one cycle of inputs, then let outputs settle just after the edge.
  task automatic applyStimulus(input logic r, input logic f, input logic v,
                               input logic rd, input logic [DW-1:0] d);
    rst     = r;
    i_flush = f;
    i_valid = v;
    i_ready = rd;
    i_din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(logic r, logic f, logic v, logic rd, logic [DW-1:0] d,
                              logic ev, int ec, logic cd, logic [DW-1:0] ed, logic er);
    vec_t t;
    t.rst = r; t.flush = f; t.valid = v; t.ready = rd; t.din = d;
    t.expValid = ev; t.expCount = ec; t.chkDout = cd; t.expDout = ed; t.expReady = er;
    return t;
  endfunction

  // Reference model state: the stored words in arrival order.
  logic [DW-1:0] q[$];

  initial begin
    logic          pendingPush;
    logic [DW-1:0] heldDin;
    logic          v;
    logic          rd;
    logic          f;
    logic [DW-1:0] d;
    logic          mReady;
    logic          mValid;
    logic          stall;
    logic [DW-1:0] prevDout;

    checks = 0;
    errors = 0;
    rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_din = '0;

    // Reset with a write attempt, release, then fill to full and drain in order.
    vecs.push_back(mk(1, 0, 1, 0, 32'hDEAD, 0, 0, 1, 32'h0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'hDEAD, 0, 0, 1, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,    0, 0, 1, 32'h0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 32'd1,    1, 1, 1, 32'd1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 32'd2,    1, 2, 1, 32'd1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 32'd3,    1, 3, 1, 32'd1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 32'd4,    1, 4, 1, 32'd1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'd5,    1, 4, 1, 32'd1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'd0,    1, 3, 1, 32'd2, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'd0,    1, 2, 1, 32'd3, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'd0,    1, 1, 1, 32'd4, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'd0,    0, 0, 0, 32'd0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].valid, vecs[i].ready, vecs[i].din);
      checkOutput($sformatf("vec%0d.valid", i), DW'(o_valid), DW'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d.count", i), DW'(o_count), DW'(vecs[i].expCount));
      checkOutput($sformatf("vec%0d.ready", i), DW'(o_ready), DW'(vecs[i].expReady));
      if (vecs[i].chkDout)
        checkOutput($sformatf("vec%0d.dout", i), o_dout, vecs[i].expDout);
    end

    // Streaming: each word visible one cycle after its push, count pinned at 1.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0, 1, 1, DW'(k));
      checkOutput($sformatf("stream%0d.count", k), DW'(o_count), 32'd1);
      checkOutput($sformatf("stream%0d.dout", k), o_dout, DW'(k));
    end
    applyStimulus(0, 0, 0, 1, 32'd0);
    checkOutput("stream.end.count", DW'(o_count), 32'd0);

    // Full with simultaneous pop: pop only, then push and pop together.
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, 0, DW'(10 + k));
    checkOutput("full.ready", DW'(o_ready), 32'd0);
    applyStimulus(0, 0, 1, 1, 32'd14);
    checkOutput("fullpop.count", DW'(o_count), 32'd3);
    checkOutput("fullpop.dout", o_dout, 32'd11);
    checkOutput("fullpop.ready", DW'(o_ready), 32'd1);
    applyStimulus(0, 0, 1, 1, 32'd14);
    checkOutput("fullpop2.count", DW'(o_count), 32'd3);
    checkOutput("fullpop2.dout", o_dout, 32'd12);
    applyStimulus(0, 1, 0, 0, 32'd0);
    checkOutput("fullpop.flush.count", DW'(o_count), 32'd0);

    // Flush beats a same-cycle push and pop; the next push shows up one cycle later.
    applyStimulus(0, 0, 1, 0, 32'hA0);
    applyStimulus(0, 0, 1, 0, 32'hA1);
    checkOutput("flush.pre.count", DW'(o_count), 32'd2);
    applyStimulus(0, 1, 1, 1, 32'hEE);
    checkOutput("flush.count", DW'(o_count), 32'd0);
    checkOutput("flush.valid", DW'(o_valid), 32'd0);
    applyStimulus(0, 0, 1, 0, 32'hA5);
    checkOutput("postflush.valid", DW'(o_valid), 32'd1);
    checkOutput("postflush.dout", o_dout, 32'hA5);
    checkOutput("postflush.count", DW'(o_count), 32'd1);
    applyStimulus(0, 1, 0, 0, 32'd0);
    q.delete();

    // Random traffic with back-pressure and occasional flush against the queue model.
    pendingPush = 1'b0;
    heldDin     = '0;
    for (int c = 0; c < 1000; c++) begin
      if (pendingPush) begin
        v = 1'b1;
        d = heldDin;
      end else begin
        v = 1'($urandom_range(0, 1));
        d = $urandom;
      end
      rd = 1'($urandom_range(0, 1));
      f  = ($urandom_range(0, 99) < 2);

      mReady   = (q.size() != DEPTH);
      mValid   = (q.size() != 0);
      stall    = mValid && !rd && !f;
      prevDout = mValid ? q[0] : '0;
      pendingPush = v && !mReady;
      heldDin     = d;

      applyStimulus(0, f, v, rd, d);

      if (f) begin
        q.delete();
      end else begin
        if (mValid && rd) void'(q.pop_front());
        if (v && mReady) q.push_back(d);
      end

      checkOutput($sformatf("rand%0d.count", c), DW'(o_count), DW'(q.size()));
      checkOutput($sformatf("rand%0d.valid", c), DW'(o_valid), DW'(q.size() != 0));
      checkOutput($sformatf("rand%0d.ready", c), DW'(o_ready), DW'(q.size() != DEPTH));
      if (q.size() != 0)
        checkOutput($sformatf("rand%0d.dout", c), o_dout, q[0]);
      if (stall) begin
        checkOutput($sformatf("rand%0d.hold.valid", c), DW'(o_valid), 32'd1);
        checkOutput($sformatf("rand%0d.hold.dout", c), o_dout, prevDout);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_fifo.md
# pipe_fifo

Parametrised synchronous FIFO pipeline buffer with a valid/ready handshake on both sides, first-word fall-through output, occupancy count and a synchronous flush. It generalises the single-entry enable register (`dff`) to DEPTH entries with back-pressure. It sits between pipeline stages, for example fetch→decode or issue→execute, where a stage must absorb bursts and be cleared on a branch or exception redirect.

## Interface
- DATA_WIDTH, 32, width of each entry.
- DEPTH, 4, number of entries; power of two, ≥2.
- PTR_W (localparam), $clog2(DEPTH), pointer width; the count is PTR_W+1 bits.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_flush  in  1  synchronous flush; discards all entries.
- i_valid  in  1  upstream has data on i_din.
- o_ready  out  1  FIFO can accept a write this cycle.
- i_din  in  DATA_WIDTH  write data.
- o_valid  out  1  o_dout holds the oldest valid entry.
- i_ready  in  1  downstream accepts o_dout this cycle.
- o_dout  out  DATA_WIDTH  oldest entry (first-word fall-through).
- o_count  out  PTR_W+1  number of stored entries, 0..DEPTH.

## Operation
- State: mem[DEPTH], wr_ptr and rd_ptr (PTR_W bits each), count (PTR_W+1 bits).
- push = i_valid & o_ready; pop = o_valid & i_ready.
- o_ready = (count != DEPTH) & ~rst. It depends only on registered state, never on i_ready. A full FIFO does not accept a write even in a cycle that pops.
- o_valid = (count != 0). o_dout = mem[rd_ptr], combinational from registers. o_count = count.
- On push: mem[wr_ptr] <= i_din; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- On pop: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Count update: push only → +1; pop only → −1; both → unchanged; neither → unchanged.
- Flush has priority. When i_flush=1, any same-cycle push and pop are discarded. wr_ptr, rd_ptr and count go to 0 at the next edge. mem contents are left as-is; they are unobservable because o_valid=0.
- Reset has priority over flush. rst=1 clears pointers, count and every mem entry to 0.
- While a valid/ready handshake is pending (the other side not ready), upstream must hold i_valid and i_din stable, and o_dout/o_valid hold stable. This is not checked by the block; the bench asserts it.

## Timing
- Reset values, from the cycle after rst is sampled high:
  - o_valid=0, o_count=0, o_dout=0.
  - o_ready=0 while rst=1; o_ready=1 in the first cycle with rst=0.
- Write-to-read latency is 1 cycle. Data pushed at edge N appears on o_dout with o_valid=1 in cycle N+1.
- Throughput is 1 push and 1 pop per cycle when 0<count<DEPTH.
- Empty with simultaneous push: no pop is possible that cycle (o_valid=0). Count becomes 1.
- Full (count=DEPTH): o_ready=0. A pop frees a slot, and o_ready=1 from the next cycle.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble.
- Reset or flush in the middle of a burst: output is empty in the next cycle. The first post-flush push is visible one cycle after it is accepted.
- There is no combinational path i_ready→o_ready or i_valid→o_valid.

## Test plan
- Reset: hold rst for 2 cycles with i_valid=1 and i_din=32'hDEAD → o_valid=0, o_count=0, o_dout=0, o_ready=0 during reset. After release, o_ready=1 and nothing was written.
- Fill/drain (DEPTH=4): push 1,2,3,4 with i_ready=0 → o_count 1,2,3,4, then o_ready=0. A 5th word is held off. Raise i_ready → pops 1,2,3,4 in order, then o_valid=0 and o_ready=1.
- Streaming wrap: constant i_valid=i_ready=1 for 10 words 0..9 → each word appears 1 cycle after its push. o_count stays at 1, pointers wrap twice, no loss or duplication.
- Full with simultaneous pop: count=4, i_valid=1, i_ready=1 → that cycle pop only, count=3. Next cycle the push is accepted and count stays 3.
- Flush priority: count=2, assert i_flush with i_valid=1 and i_ready=1 → next cycle count=0 and o_valid=0. The pushed word never appears. A following push of 8'hA5 appears 1 cycle later.
- Random back-pressure: 1000 cycles of random i_valid/i_ready/i_flush (flush 2%) against a scoreboard → exact order is preserved and o_count always matches the model.
